// File: rtl/sram_arbiter_if.sv
// Request/response and SRAM bus bundle for the two-requester SRAM arbiter.
// The arbiter connects through the slave modport; requesters and the SRAM side use master.
interface sram_arbiter_if #(
    parameter int addr_width = 18,
    parameter int data_width = 16
);
    logic                  req_valid_0;
    logic                  req_valid_1;
    logic                  req_write_0;
    logic                  req_write_1;
    logic [addr_width-1:0] req_addr_0;
    logic [addr_width-1:0] req_addr_1;
    logic [data_width-1:0] req_wdata_0;
    logic [data_width-1:0] req_wdata_1;
    logic                  req_ready_0;
    logic                  req_ready_1;
    logic                  rsp_valid_0;
    logic                  rsp_valid_1;
    logic [data_width-1:0] rsp_rdata;
    logic [addr_width-1:0] sram_addr;
    logic [data_width-1:0] sram_wdata;
    logic                  sram_data_oe;
    logic [data_width-1:0] sram_rdata;
    logic                  sram_ce_n;
    logic                  sram_we_n;
    logic                  sram_oe_n;

    modport slave (
        input  req_valid_0, req_valid_1, req_write_0, req_write_1,
        input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, sram_rdata,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata,
        output sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_we_n, sram_oe_n
    );

    modport master (
        output req_valid_0, req_valid_1, req_write_0, req_write_1,
        output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, sram_rdata,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata,
        input  sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between two requesters.
// Each access: IDLE (grant) -> ACCESS for wait_cycles cycles -> DONE (turnaround + response).
module sram_arbiter #(
    parameter int addr_width  = 18,
    parameter int data_width  = 16,
    parameter int wait_cycles = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  id_q, id_d;
    logic                  write_q, write_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic [data_width-1:0] rdata_q, rdata_d;

    logic any_valid;
    logic grant_id;
    logic accept;

    // On a tie the requester that did not win last time is chosen.
    assign any_valid = bus.req_valid_0 | bus.req_valid_1;
    assign grant_id  = (bus.req_valid_0 & bus.req_valid_1) ? ~last_grant_q : bus.req_valid_1;
    assign accept    = (state_q == IDLE) & any_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ACCESS;
                    cnt_d        = 4'(wait_cycles);
                    last_grant_d = grant_id;
                    id_d         = grant_id;
                    write_d      = grant_id ? bus.req_write_1 : bus.req_write_0;
                    addr_d       = grant_id ? bus.req_addr_1  : bus.req_addr_0;
                    wdata_d      = grant_id ? bus.req_wdata_1 : bus.req_wdata_0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                // Last strobe cycle: read data is sampled while oe_n is still low.
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (!write_q) begin
                        rdata_d = bus.sram_rdata;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_0  = rst_n & accept & ~grant_id;
        bus.req_ready_1  = rst_n & accept & grant_id;
        bus.rsp_valid_0  = 1'b0;
        bus.rsp_valid_1  = 1'b0;
        bus.sram_ce_n    = 1'b1;
        bus.sram_we_n    = 1'b1;
        bus.sram_oe_n    = 1'b1;
        bus.sram_data_oe = 1'b0;
        case (state_q)
            ACCESS: begin
                bus.sram_ce_n = 1'b0;
                if (write_q) begin
                    bus.sram_we_n    = 1'b0;
                    bus.sram_data_oe = 1'b1;
                end else begin
                    bus.sram_oe_n = 1'b0;
                end
            end
            DONE: begin
                bus.rsp_valid_0 = ~id_q;
                bus.rsp_valid_1 = id_q;
            end
            default: ;
        endcase
    end

    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.rsp_rdata  = rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: timeline-based reference model checked every cycle on the
// wait_cycles=2 instance, plus directed strobe-width/latency probes on 1 and 15.
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int WC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    sram_arbiter_if #(.addr_width(AW), .data_width(DW)) bus ();
    sram_arbiter_if #(.addr_width(AW), .data_width(DW)) bus_w1 ();
    sram_arbiter_if #(.addr_width(AW), .data_width(DW)) bus_w15 ();

    sram_arbiter #(.addr_width(AW), .data_width(DW), .wait_cycles(WC))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    sram_arbiter #(.addr_width(AW), .data_width(DW), .wait_cycles(1))
        u_dut_w1 (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
    sram_arbiter #(.addr_width(AW), .data_width(DW), .wait_cycles(15))
        u_dut_w15 (.clk(clk), .rst_n(rst_n), .bus(bus_w15));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // SRAM behavioural model for the main instance
    logic [DW-1:0] sram_mem [256];
    logic [DW-1:0] ref_mem  [256];
    assign bus.sram_rdata = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_addr[7:0]] : 16'h0BAD;
    always @(posedge clk) if (!bus.sram_ce_n && !bus.sram_we_n) sram_mem[bus.sram_addr[7:0]] <= bus.sram_wdata;
    assign bus_w1.sram_rdata  = '0;
    assign bus_w15.sram_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: m_k counts cycles since the accepting edge (0 = arbiter free).
    int            m_k    = 0;
    bit            m_last = 1'b1;
    bit            m_id   = 1'b0;
    bit            m_wr   = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    int            g_id[$], g_cyc[$], r_id[$], r_cyc[$], we_w[$], oe_w[$];
    logic [DW-1:0] r_data[$];
    int            we_run = 0;
    int            oe_run = 0;

    always @(negedge clk) begin
        bit acc, dn, idl, v0, v1, g;
        if (!rst_n) begin
            chk("rst_ready_0", bus.req_ready_0, 0);
            chk("rst_ready_1", bus.req_ready_1, 0);
            chk("rst_rsp", {bus.rsp_valid_0, bus.rsp_valid_1}, 0);
            chk("rst_strobes", {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 3'b111);
            chk("rst_data_oe", bus.sram_data_oe, 0);
            chk("rst_addr", bus.sram_addr, 0);
            chk("rst_wdata", bus.sram_wdata, 0);
            chk("rst_rdata", bus.rsp_rdata, 0);
            m_k = 0; m_last = 1'b1; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            v0  = bus.req_valid_0;
            v1  = bus.req_valid_1;
            idl = (m_k == 0);
            acc = (m_k >= 1) && (m_k <= WC);
            dn  = (m_k == WC + 1);
            g   = (v0 && v1) ? !m_last : v1;
            chk("ready_0", bus.req_ready_0, idl && (v0 || v1) && !g);
            chk("ready_1", bus.req_ready_1, idl && (v0 || v1) && g);
            chk("rsp_valid_0", bus.rsp_valid_0, dn && !m_id);
            chk("rsp_valid_1", bus.rsp_valid_1, dn && m_id);
            chk("ce_n", bus.sram_ce_n, !acc);
            chk("we_n", bus.sram_we_n, !(acc && m_wr));
            chk("oe_n", bus.sram_oe_n, !(acc && !m_wr));
            chk("data_oe", bus.sram_data_oe, acc && m_wr);
            chk("sram_addr", bus.sram_addr, m_addr);
            chk("sram_wdata", bus.sram_wdata, m_wdata);
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
            if (idl && (v0 || v1)) begin
                m_k = 1; m_id = g; m_last = g;
                m_wr    = g ? bus.req_write_1 : bus.req_write_0;
                m_addr  = g ? bus.req_addr_1  : bus.req_addr_0;
                m_wdata = g ? bus.req_wdata_1 : bus.req_wdata_0;
            end else if (acc) begin
                if (m_k == WC) begin
                    if (m_wr) ref_mem[m_addr[7:0]] = m_wdata;
                    else      m_rdata = ref_mem[m_addr[7:0]];
                end
                m_k++;
            end else if (dn) begin
                m_k = 0;
            end
        end
        if (bus.req_ready_0) begin g_id.push_back(0); g_cyc.push_back(cyc); end
        if (bus.req_ready_1) begin g_id.push_back(1); g_cyc.push_back(cyc); end
        if (bus.rsp_valid_0 || bus.rsp_valid_1) begin
            r_id.push_back(bus.rsp_valid_1 ? 1 : 0); r_cyc.push_back(cyc); r_data.push_back(bus.rsp_rdata);
        end
        if (!bus.sram_we_n) we_run++; else if (we_run > 0) begin we_w.push_back(we_run); we_run = 0; end
        if (!bus.sram_oe_n) oe_run++; else if (oe_run > 0) begin oe_w.push_back(oe_run); oe_run = 0; end
    end

    task automatic clear_logs();
        g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete();
        r_data.delete(); we_w.delete(); oe_w.delete();
    endtask

    task automatic drive(input int id, input bit v, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            bus.req_valid_0 = v; bus.req_write_0 = wr; bus.req_addr_0 = a; bus.req_wdata_0 = d;
        end else begin
            bus.req_valid_1 = v; bus.req_write_1 = wr; bus.req_addr_1 = a; bus.req_wdata_1 = d;
        end
    endtask

    task automatic wait_accept(input int id);
        bit got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            got = (id == 0) ? bus.req_ready_0 : bus.req_ready_1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout_%0d: no req_ready in 60 cycles, expected a grant", id);
        end
        @(posedge clk); #1;
    endtask

    // Keeps valid high across n back-to-back requests, then drops it.
    task automatic run_req(input int id, input int n, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            drive(id, 1'b1, wr, a + AW'(k), d + DW'(k));
            wait_accept(id);
        end
        drive(id, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic aux_txn(input int which, output int width, output int lat);
        int rc   = -1;
        int wcnt = 0;
        bit rdy, we_n, rsp;
        lat = -1;
        @(posedge clk); #1;
        if (which == 1) begin
            bus_w1.req_valid_0 = 1'b1; bus_w1.req_write_0 = 1'b1; bus_w1.req_addr_0 = 18'h7; bus_w1.req_wdata_0 = 16'h5555;
        end else begin
            bus_w15.req_valid_0 = 1'b1; bus_w15.req_write_0 = 1'b1; bus_w15.req_addr_0 = 18'h7; bus_w15.req_wdata_0 = 16'h5555;
        end
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            rdy  = (which == 1) ? bus_w1.req_ready_0 : bus_w15.req_ready_0;
            we_n = (which == 1) ? bus_w1.sram_we_n   : bus_w15.sram_we_n;
            rsp  = (which == 1) ? bus_w1.rsp_valid_0 : bus_w15.rsp_valid_0;
            if (!we_n) wcnt++;
            if (rsp && rc >= 0) lat = i - rc;
            if (rdy && rc < 0) begin
                rc = i;
                @(posedge clk); #1;
                if (which == 1) bus_w1.req_valid_0 = 1'b0; else bus_w15.req_valid_0 = 1'b0;
            end
        end
        width = wcnt;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL aux_timeout_w%0d: no rsp_valid_0 within 40 cycles, expected one", which);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int w, l, nrsp;
        for (int i = 0; i < 256; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        sram_mem[32] = 16'h1234;
        ref_mem[32]  = 16'h1234;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        bus_w1.req_valid_0 = 1'b0; bus_w1.req_valid_1 = 1'b0; bus_w1.req_write_0 = 1'b0; bus_w1.req_write_1 = 1'b0;
        bus_w1.req_addr_0 = '0; bus_w1.req_addr_1 = '0; bus_w1.req_wdata_0 = '0; bus_w1.req_wdata_1 = '0;
        bus_w15.req_valid_0 = 1'b0; bus_w15.req_valid_1 = 1'b0; bus_w15.req_write_0 = 1'b0; bus_w15.req_write_1 = 1'b0;
        bus_w15.req_addr_0 = '0; bus_w15.req_addr_1 = '0; bus_w15.req_wdata_0 = '0; bus_w15.req_wdata_1 = '0;

        // Reset with a pending request: ready must stay low while rst_n is low
        #1 rst_n = 1'b0;
        bus.req_valid_0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready_held_low", bus.req_ready_0, 0);
        chk("reset_ce_n", bus.sram_ce_n, 1);
        bus.req_valid_0 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Single write
        clear_logs();
        run_req(0, 1, 1'b1, 18'h00010, 16'hBEEF);
        repeat (6) @(posedge clk); #1;
        chk("wr_grant_count", g_id.size(), 1);
        chk("wr_grant_id", g_id[0], 0);
        chk("wr_we_width_count", we_w.size(), 1);
        chk("wr_we_width", we_w[0], 2);
        chk("wr_rsp_id", r_id[0], 0);
        chk("wr_latency", r_cyc[0] - g_cyc[0], 3);

        // Single read
        clear_logs();
        run_req(1, 1, 1'b0, 18'h00020, '0);
        repeat (6) @(posedge clk); #1;
        chk("rd_oe_width", oe_w[0], 2);
        chk("rd_rsp_id", r_id[0], 1);
        chk("rd_rdata", r_data[0], 16'h1234);
        chk("rd_latency", r_cyc[0] - g_cyc[0], 3);

        // Contention after reset
        do_reset();
        clear_logs();
        fork
            run_req(0, 2, 1'b1, 18'h00030, 16'h3000);
            run_req(1, 2, 1'b0, 18'h00020, '0);
        join
        repeat (8) @(posedge clk); #1;
        chk("ct_grant_count", g_id.size(), 4);
        chk("ct_grant_0", g_id[0], 0);
        chk("ct_grant_1", g_id[1], 1);
        chk("ct_grant_2", g_id[2], 0);
        chk("ct_grant_3", g_id[3], 1);
        chk("ct_rsp_gap_1", r_cyc[1] - r_cyc[0], 4);
        chk("ct_rsp_gap_2", r_cyc[2] - r_cyc[1], 4);
        chk("ct_rsp_gap_3", r_cyc[3] - r_cyc[2], 4);

        // Reset during a write access
        clear_logs();
        run_req(0, 1, 1'b1, 18'h00050, 16'h7777);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_strobes", {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 3'b111);
        chk("abort_data_oe", bus.sram_data_oe, 0);
        drive(0, 1'b1, 1'b1, 18'h00051, 16'h1111);
        drive(1, 1'b1, 1'b0, 18'h00020, '0);
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nrsp = r_id.size();
        chk("abort_no_rsp", nrsp, 0);
        fork
            begin wait_accept(0); drive(0, 1'b0, 1'b0, '0, '0); end
            begin wait_accept(1); drive(1, 1'b0, 1'b0, '0, '0); end
        join
        repeat (6) @(posedge clk); #1;
        chk("abort_first_grant", g_id[0], 0);
        chk("abort_second_grant", g_id[1], 1);
        chk("abort_rsp_count", r_id.size(), 2);

        // Write then read back through the other requester
        clear_logs();
        run_req(1, 1, 1'b0, 18'h00020, '0);
        run_req(0, 1, 1'b1, 18'h00060, 16'hA5A5);
        repeat (6) @(posedge clk); #1;
        chk("wb_rdata_after_write", bus.rsp_rdata, 16'h1234);
        chk("wb_write_rsp_rdata", r_data[1], 16'h1234);
        run_req(1, 1, 1'b0, 18'h00060, '0);
        repeat (6) @(posedge clk); #1;
        chk("wb_readback", r_data[2], 16'hA5A5);
        chk("wb_readback_id", r_id[2], 1);

        // Strobe width and latency at the wait_cycles extremes
        aux_txn(1, w, l);
        chk("w1_strobe_width", w, 1);
        chk("w1_latency", l, 2);
        aux_txn(15, w, l);
        chk("w15_strobe_width", w, 15);
        chk("w15_latency", l, 16);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
